// File: rtl/sensor_display_pkg.sv
// Shared types and constants for the sensor/status panel 7-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a} with 1 meaning lit.
package sensor_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t HEX7_ROM [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sensor_display_scan_decoder.sv
// Combinational hex digit to 7-segment pattern lookup (active-high segments).
module seg7_hex_decoder
  import sensor_display_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  assign seg = HEX7_ROM[code];

endmodule

// File: rtl/sensor_display_scan.sv
// Time-multiplexed N-digit 7-segment driver with tear-free frame updates,
// per-digit blink/blank, dead time at each slot start and selectable polarity.
module sensor_display_scan
  import sensor_display_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYC    = 2,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] codes_i,
  input  logic                  load_i,
  input  logic [N_DIGITS-1:0]   blink_en_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  output logic [6:0]            seg_o,
  output logic [N_DIGITS-1:0]   dig_o,
  output logic                  frame_o
);

  localparam int unsigned PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int unsigned IW = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [0:0] PH_ON  = 1'b0;
  localparam logic [0:0] PH_OFF = 1'b1;

  // Polarity is applied as an XOR mask on the final registered value.
  localparam seg_t                SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_POL = {N_DIGITS{ACTIVE_LOW}};

  typedef struct packed {
    logic [4*N_DIGITS-1:0] codes;
    logic [N_DIGITS-1:0]   blink_en;
    logic [N_DIGITS-1:0]   blank;
  } frame_cfg_t;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_ctr;
  logic [0:0]    phase;
  logic          pending;
  frame_cfg_t    shadow;
  frame_cfg_t    active;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_code;
  logic                cur_blank;
  logic                cur_blink;
  logic [N_DIGITS-1:0] dig_sel;
  logic                visible;
  seg_t                dec_seg;
  seg_t                seg_next;
  logic [N_DIGITS-1:0] dig_next;

  assign tick    = (presc == PRESC_LAST);
  assign wrap    = tick && (idx == IDX_LAST);
  assign frame_o = wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A load coinciding with a wrap keeps pending set so the new data waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap && pending)
        active <= shadow;
      if (load_i) begin
        shadow  <= '{codes: codes_i, blink_en: blink_en_i, blank: blank_i};
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ctr <= '0;
      phase     <= PH_ON;
    end else if (wrap) begin
      if (frame_ctr == FRAME_LAST) begin
        frame_ctr <= '0;
        phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        frame_ctr <= frame_ctr + 1'b1;
      end
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    dig_sel   = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (32'(idx) == k) begin
        cur_code   = active.codes[4*k +: 4];
        cur_blank  = active.blank[k];
        cur_blink  = active.blink_en[k];
        dig_sel[k] = 1'b1;
      end
    end
  end

  assign visible = !cur_blank && !(cur_blink && (phase == PH_OFF));

  seg7_hex_decoder u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    seg_next = SEG_OFF;
    dig_next = '0;
    if (presc >= BLANK_END) begin
      dig_next = dig_sel;
      seg_next = visible ? dec_seg : SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_o <= SEG_OFF ^ SEG_POL;
      dig_o <= DIG_POL;
    end else begin
      seg_o <= seg_next ^ SEG_POL;
      dig_o <= dig_next ^ DIG_POL;
    end
  end

endmodule

// File: tb/tb_sensor_display_scan.sv
// Directed bench for sensor_display_scan: reset, scan order, tear-free loads,
// blink, blank and active-low polarity on a 4-digit, 4-cycle-slot build.
module tb_sensor_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] codes = '0;
  logic        load = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [3:0]  blank = '0;

  logic [6:0]  seg, seg_al;
  logic [3:0]  dig, dig_al;
  logic        frame, frame_al;

  int checks = 0;
  int errors = 0;
  int unsigned wraps = 0;
  int unsigned cap_wraps = 0;

  logic [6:0] obs_seg [16];
  logic [3:0] obs_dig [16];
  logic       obs_frm [16];

  always #5 clk = ~clk;

  sensor_display_scan #(
    .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .codes_i(codes), .load_i(load),
    .blink_en_i(blink_en), .blank_i(blank),
    .seg_o(seg), .dig_o(dig), .frame_o(frame)
  );

  sensor_display_scan #(
    .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rst(rst), .codes_i(codes), .load_i(load),
    .blink_en_i(blink_en), .blank_i(blank),
    .seg_o(seg_al), .dig_o(dig_al), .frame_o(frame_al)
  );

  // Wraps since reset; after n wraps the blink phase is off when (n/2) is odd.
  always @(negedge clk) begin
    if (rst) wraps <= 0;
    else if (frame === 1'b1) wraps <= wraps + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100000");
    $fatal(1);
  end

  task automatic drive_load(input logic [15:0] c, input logic [3:0] bl, input logic [3:0] bk);
    @(negedge clk);
    codes = c; blink_en = bl; blank = bk; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits for a frame_o cycle F, then records outputs of cycles F+1..F+16.
  task automatic capture_frame(output bit ok);
    int unsigned n = 0;
    ok = 1'b1;
    while (frame !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 64) begin
        ok = 1'b0;
        return;
      end
    end
    #1 cap_wraps = wraps;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      obs_seg[i] = seg;
      obs_dig[i] = dig;
      obs_frm[i] = frame;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 7'h00 || dig !== 4'h0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: seg=%h dig=%h frame=%b, required 00 0 0", seg, dig, frame);
    end
    checks++;
    if (seg_al !== 7'h7F || dig_al !== 4'hF || frame_al !== 1'b0) begin
      errors++;
      $display("FAIL reset_active_low: seg=%h dig=%h frame=%b, required 7f f 0", seg_al, dig_al, frame_al);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seg !== 7'h3F || dig !== 4'h1) begin
      errors++;
      $display("FAIL first_slot: seg=%h dig=%h, required 3f 1", seg, dig);
    end
    checks++;
    if (seg_al !== 7'h40 || dig_al !== 4'hE) begin
      errors++;
      $display("FAIL first_slot_al: seg=%h dig=%h, required 40 e", seg_al, dig_al);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (seg !== 7'h00 || dig !== 4'h0) begin
      errors++;
      $display("FAIL reset_async: seg=%h dig=%h, required 00 0", seg, dig);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seg !== 7'h3F || dig !== 4'h1) begin
      errors++;
      $display("FAIL first_slot_rerun: seg=%h dig=%h, required 3f 1", seg, dig);
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [6:0] exp_s [4];
    logic [6:0] es;
    logic [3:0] ed;
    bit frm_bad;
    int k, j;
    exp_s = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    drive_load(16'h4321, 4'b0000, 4'b0000);
    capture_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_timeout: frame_o not seen, required within 64 cycles");
    end
    checks++;
    if (obs_seg[0] !== 7'h3F || obs_dig[0] !== 4'h8) begin
      errors++;
      $display("FAIL scan_prewrap: seg=%h dig=%h, required 3f 8", obs_seg[0], obs_dig[0]);
    end
    for (int i = 1; i < 16; i++) begin
      k = (i - 1) / 4;
      j = (i - 1) % 4;
      es = (j == 0) ? 7'h00 : exp_s[k];
      ed = (j == 0) ? 4'h0 : 4'(1 << k);
      checks++;
      if (obs_seg[i] !== es || obs_dig[i] !== ed) begin
        errors++;
        $display("FAIL scan_slot i=%0d: seg=%h dig=%h, required %h %h", i, obs_seg[i], obs_dig[i], es, ed);
      end
    end
    frm_bad = 1'b0;
    for (int i = 0; i < 15; i++)
      if (obs_frm[i] !== 1'b0) frm_bad = 1'b1;
    checks++;
    if (frm_bad || obs_frm[15] !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: early=%b at16=%b, required 0 1", frm_bad, obs_frm[15]);
    end
  endtask

  task automatic test_polarity();
    int unsigned n = 0;
    while (frame !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL polarity_timeout: frame=%b, required 1", frame);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 7'h06 || dig !== 4'h1) begin
      errors++;
      $display("FAIL polarity_ref: seg=%h dig=%h, required 06 1", seg, dig);
    end
    checks++;
    if (seg_al !== 7'h79 || dig_al !== 4'hE) begin
      errors++;
      $display("FAIL polarity_al: seg=%h dig=%h, required 79 e", seg_al, dig_al);
    end
  endtask

  // Entered at cycle F+3 of a frame showing 4321.
  task automatic test_tearfree();
    bit ok;
    bit bad;
    repeat (7) @(negedge clk);
    codes = 16'h0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (seg !== 7'h4F || dig !== 4'h4) begin
      errors++;
      $display("FAIL tear_digit2: seg=%h dig=%h, required 4f 4", seg, dig);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (frame !== 1'b1 || seg !== 7'h66 || dig !== 4'h8) begin
      errors++;
      $display("FAIL tear_digit3: frame=%b seg=%h dig=%h, required 1 66 8", frame, seg, dig);
    end
    capture_frame(ok);
    checks++;
    if (!ok || obs_seg[0] !== 7'h66 || obs_dig[0] !== 4'h8) begin
      errors++;
      $display("FAIL tear_prewrap: ok=%b seg=%h dig=%h, required 1 66 8", ok, obs_seg[0], obs_dig[0]);
    end
    bad = 1'b0;
    for (int i = 2; i < 16; i++)
      if (((i - 1) % 4) != 0 && obs_seg[i] !== 7'h3F) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL tear_new_frame: seg i2=%h i14=%h, required all 3f", obs_seg[2], obs_seg[14]);
    end
    // Now on a frame_o cycle: a load here must wait a whole extra frame.
    codes = 16'h9999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seg !== 7'h3F || dig !== 4'h1) begin
      errors++;
      $display("FAIL load_on_wrap_held: seg=%h dig=%h, required 3f 1", seg, dig);
    end
    capture_frame(ok);
    bad = 1'b0;
    for (int i = 2; i < 16; i++)
      if (((i - 1) % 4) != 0 && obs_seg[i] !== 7'h6F) bad = 1'b1;
    checks++;
    if (!ok || bad) begin
      errors++;
      $display("FAIL load_on_wrap_applied: ok=%b seg i2=%h i14=%h, required 1 6f 6f", ok, obs_seg[2], obs_seg[14]);
    end
  endtask

  task automatic test_blink();
    bit ok;
    logic [6:0] es;
    drive_load(16'h0008, 4'b0001, 4'b0000);
    for (int f = 0; f < 4; f++) begin
      capture_frame(ok);
      es = (((cap_wraps / 2) % 2) == 0) ? 7'h7F : 7'h00;
      checks++;
      if (!ok || obs_seg[2] !== es || obs_seg[3] !== es || obs_dig[2] !== 4'h1) begin
        errors++;
        $display("FAIL blink_digit0 f=%0d wraps=%0d: ok=%b seg=%h/%h dig=%h, required 1 %h 1",
                 f, cap_wraps, ok, obs_seg[2], obs_seg[3], obs_dig[2], es);
      end
      checks++;
      if (obs_seg[6] !== 7'h3F || obs_dig[6] !== 4'h2) begin
        errors++;
        $display("FAIL blink_other f=%0d: seg=%h dig=%h, required 3f 2", f, obs_seg[6], obs_dig[6]);
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    drive_load(16'h1234, 4'b0000, 4'b1000);
    capture_frame(ok);
    checks++;
    if (!ok || obs_seg[14] !== 7'h00 || obs_dig[14] !== 4'h8) begin
      errors++;
      $display("FAIL blank_digit3: ok=%b seg=%h dig=%h, required 1 00 8", ok, obs_seg[14], obs_dig[14]);
    end
    checks++;
    if (obs_seg[2] !== 7'h66 || obs_seg[6] !== 7'h4F || obs_seg[10] !== 7'h5B) begin
      errors++;
      $display("FAIL blank_others: seg=%h %h %h, required 66 4f 5b", obs_seg[2], obs_seg[6], obs_seg[10]);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_polarity();
    test_tearfree();
    test_blink();
    test_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
